mext_ctrl: RTL and testbench



---
 rtl/mext_pkg.sv | 37 +++
 rtl/mext_ctrl_div_iter.sv | 63 ++++++
 rtl/mext_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mext_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mext_pkg.sv
// Shared types and constants for the M-extension sequencer and its divider core.
package mext_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] MULSEL_MUL    = 2'b00;
    localparam logic [1:0] MULSEL_MULH   = 2'b01;
    localparam logic [1:0] MULSEL_MULHSU = 2'b10;
    localparam logic [1:0] MULSEL_MULHU  = 2'b11;

    localparam int DIV_ITER = 32;

    localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUO  = 32'h8000_0000;
    localparam logic [31:0] OVF_REM  = 32'h0000_0000;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE  = 32'hFFFF_FFFF;

    function automatic logic [31:0] cond_neg(input logic [31:0] val, input logic neg);
        cond_neg = neg ? (32'd0 - val) : val;
    endfunction

endpackage

// File: rtl/mext_ctrl_div_iter.sv
// Restoring radix-2 unsigned divider: one quotient bit per cycle after load.
// quotient_o/remainder_o show the result of the step taken on the coming edge.
module div_iter
    import mext_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        done_o
);
    localparam int CW = $clog2(DIV_ITER + 1);

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_quo;
    logic [31:0]   r_rem;
    logic [31:0]   r_dvs;
    logic [32:0]   w_shift;
    logic [32:0]   w_diff;
    logic          w_bit;
    logic [31:0]   w_quo_nxt;
    logic [31:0]   w_rem_nxt;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_shift   = {r_rem, r_quo[31]};
        w_diff    = w_shift - {1'b0, r_dvs};
        w_bit     = ~w_diff[32];
        w_quo_nxt = {r_quo[30:0], w_bit};
        if (w_bit) begin
            w_rem_nxt = w_diff[31:0];
        end else begin
            w_rem_nxt = w_shift[31:0];
        end
    end

    // Iteration state; the quotient register doubles as the dividend shifter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= {CW{1'b0}};
            r_quo <= 32'd0;
            r_rem <= 32'd0;
            r_dvs <= 32'd0;
        end else if (load_i) begin
            r_cnt <= CW'(DIV_ITER);
            r_quo <= dividend_i;
            r_rem <= 32'd0;
            r_dvs <= divisor_i;
        end else if (r_cnt != {CW{1'b0}}) begin
            r_cnt <= r_cnt - CW'(1);
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
        end
    end

    assign quotient_o  = w_quo_nxt;
    assign remainder_o = w_rem_nxt;
    assign done_o      = (r_cnt == CW'(1));

endmodule

// File: rtl/mext_ctrl.sv
// M-extension sequencer: drives the external multiplier and an iterative divider.
// Define MEXT_DIV_EN to build the divider; otherwise DIV/REM ops return 0 in one cycle.
module mext_ctrl
    import mext_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    input  logic [31:0] mul_res_i,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    output logic [1:0]  mulsel_o,
    output logic        stall_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] res_o
);
    localparam int CNT_W = $clog2(MUL_LAT + 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_mul_a;
    logic [31:0]      r_mul_b;
    logic [1:0]       r_mulsel;
    logic [31:0]      r_res;
    logic             r_valid;
    logic             w_idle_like;
    logic             w_accept;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_accept    = start_i & w_idle_like & ~flush_i;

`ifdef MEXT_DIV_EN
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_b_zero;
    logic        w_ovf;
    logic        w_div_load;
    logic        w_div_done;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_special;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_div_res;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_rem_sel;

    // Magnitudes and special-case detection for the op being offered this cycle.
    always_comb begin
        w_signed = ~funct3_i[0];
        w_a_neg  = w_signed & a_i[31];
        w_b_neg  = w_signed & b_i[31];
        w_a_mag  = cond_neg(a_i, w_a_neg);
        w_b_mag  = cond_neg(b_i, w_b_neg);
        w_b_zero = (b_i == 32'd0);
        w_ovf    = w_signed & (a_i == INT_MIN) & (b_i == NEG_ONE);
        if (w_b_zero) begin
            w_special = funct3_i[1] ? a_i : DIV0_QUO;
        end else begin
            w_special = funct3_i[1] ? OVF_REM : OVF_QUO;
        end
        w_div_load = w_accept & funct3_i[2] & ~w_b_zero & ~w_ovf;
    end

    div_iter u_div_iter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (w_div_load),
        .dividend_i  (w_a_mag),
        .divisor_i   (w_b_mag),
        .quotient_o  (w_quo),
        .remainder_o (w_rem),
        .done_o      (w_div_done)
    );

    assign w_div_res = r_rem_sel ? cond_neg(w_rem, r_neg_r) : cond_neg(w_quo, r_neg_q);

    // Sign bookkeeping captured at issue, applied when the divider finishes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_rem_sel <= 1'b0;
        end else if (w_div_load) begin
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_rem_sel <= funct3_i[1];
        end
    end
`endif

    // Sequencer FSM with operand, result and valid registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= {CNT_W{1'b0}};
            r_mul_a  <= 32'd0;
            r_mul_b  <= 32'd0;
            r_mulsel <= 2'b00;
            r_res    <= 32'd0;
            r_valid  <= 1'b0;
        end else if (flush_i) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_i && !funct3_i[2]) begin
                        r_mul_a  <= a_i;
                        r_mul_b  <= b_i;
                        r_mulsel <= funct3_i[1:0];
                        r_cnt    <= CNT_W'(MUL_LAT);
                        r_state  <= ST_MUL;
                    end else if (start_i) begin
`ifdef MEXT_DIV_EN
                        if (w_b_zero || w_ovf) begin
                            r_res   <= w_special;
                            r_valid <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_DIV;
                        end
`else
                        r_res   <= 32'd0;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_res   <= mul_res_i;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
`ifdef MEXT_DIV_EN
                ST_DIV: begin
                    if (w_div_done) begin
                        r_res   <= w_div_res;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall_o  = (r_state == ST_MUL) || (r_state == ST_DIV) || w_accept;
    assign busy_o   = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign valid_o  = r_valid;
    assign res_o    = r_res;
    assign mul_a_o  = r_mul_a;
    assign mul_b_o  = r_mul_b;
    assign mulsel_o = r_mulsel;

endmodule

// File: tb/tb_mext_ctrl.sv
// Self-checking bench for mext_ctrl with a behavioural multiplier beside it.
module tb_mext_ctrl;

    logic        clk = 1'b0;
    logic        rst_i, start_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] a_i, b_i, mul_res_i;
    logic [31:0] mul_a_o, mul_b_o, res_o;
    logic [1:0]  mulsel_o;
    logic        stall_o, busy_o, valid_o;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    localparam int ML = 3;
`ifdef MEXT_DIV_EN
    localparam int DL = 33;
`else
    localparam int DL = 1;
`endif

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          lat;
        string       nm;
    } vec_t;
    vec_t tbl[$];

    mext_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .funct3_i(funct3_i),
        .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .mul_res_i(mul_res_i),
        .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mulsel_o(mulsel_o),
        .stall_o(stall_o), .busy_o(busy_o), .valid_o(valid_o), .res_o(res_o)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier returning the half selected by mulsel
    logic [63:0] m_pss, m_psu, m_puu;
    always_comb begin
        m_pss = {{32{mul_a_o[31]}}, mul_a_o} * {{32{mul_b_o[31]}}, mul_b_o};
        m_psu = {{32{mul_a_o[31]}}, mul_a_o} * {32'd0, mul_b_o};
        m_puu = {32'd0, mul_a_o} * {32'd0, mul_b_o};
        case (mulsel_o)
            2'b00:   mul_res_i = m_puu[31:0];
            2'b01:   mul_res_i = m_pss[63:32];
            2'b10:   mul_res_i = m_psu[63:32];
            default: mul_res_i = m_puu[63:32];
        endcase
    end

    function automatic logic [31:0] dres(input logic [31:0] v);
`ifdef MEXT_DIV_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int lat, input string nm);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.e = e; v.lat = lat; v.nm = nm;
        tbl.push_back(v);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, " res_o"}, res_o, 32'd0);
        chk({nm, " mul_a_o"}, mul_a_o, 32'd0);
        chk({nm, " mul_b_o"}, mul_b_o, 32'd0);
        chk({nm, " mulsel_o"}, 32'(mulsel_o), 32'd0);
        chk({nm, " valid/busy"}, 32'({valid_o, busy_o}), 32'd0);
    endtask

    // Drive an issue request in the current cycle and record the expected result.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e);
        start_i = 1'b1; funct3_i = f3; a_i = a; b_i = b;
        exp_q.push_back(e);
        #1;
        chk("stall_o in issue cycle", 32'(stall_o), 32'd1);
    endtask

    task automatic take(input string nm);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: valid_o with empty scoreboard, res_o %h", nm, res_o);
        end else begin
            e = exp_q.pop_front();
            chk({nm, " res_o"}, res_o, e);
        end
    endtask

    // Wait for valid_o, checking latency, stall/busy profile and mulsel.
    task automatic wait_done(input int lat, input string nm, input logic is_mul, input logic [1:0] sel);
        int cyc = 0;
        bit got = 1'b0;
        bit prof_bad = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start_i = 1'b0;
            #1;
            if (cyc == 1 && is_mul) chk({nm, " mulsel_o"}, 32'(mulsel_o), 32'(sel));
            if ((stall_o !== (cyc < lat)) || (busy_o !== (cyc < lat))) prof_bad = 1'b1;
            if (valid_o === 1'b1) got = 1'b1;
        end
        chk({nm, " latency"}, 32'(cyc), 32'(lat));
        chk({nm, " stall/busy profile ok"}, 32'(!prof_bad), 32'd1);
        if (got) take(nm);
        else void'(exp_q.pop_front());
    endtask

    task automatic idle(input int n, input string nm);
        bit seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (valid_o !== 1'b0) seen = 1'b1;
        end
        chk({nm, " no stray valid_o"}, 32'(seen), 32'd0);
    endtask

    // Start an op, flush it during cycle fc, then issue MUL 3x4 right after.
    task automatic flush_seq(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input int fc, input string nm);
        logic [31:0] r0;
        bit seen = 1'b0;
        @(negedge clk);
        r0 = res_o;
        start_i = 1'b1; funct3_i = f3; a_i = a; b_i = b;
        for (int c = 1; c <= fc; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (valid_o !== 1'b0) seen = 1'b1;
            if (c == fc) flush_i = 1'b1;
        end
        @(negedge clk);
        flush_i = 1'b0;
        chk({nm, " busy_o after flush"}, 32'(busy_o), 32'd0);
        chk({nm, " valid before/after flush"}, 32'({seen, valid_o}), 32'd0);
        chk({nm, " res_o retained"}, res_o, r0);
        issue(3'b000, 32'd3, 32'd4, 32'h0000_000C);
        wait_done(ML, {nm, " MUL 3x4"}, 1'b1, 2'b00);
        idle(40, nm);
    endtask

    task automatic rst_seq(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input int rc, input string nm);
        @(negedge clk);
        start_i = 1'b1; funct3_i = f3; a_i = a; b_i = b;
        for (int c = 1; c <= rc; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (c == rc) rst_i = 1'b1;
        end
        @(negedge clk);
        rst_i = 1'b0;
        check_reset(nm);
        idle(40, nm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        add(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, ML, "MULH -1*-1");
        add(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML, "MULHU max*max");
        add(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, ML, "MULHSU -1*2");
        add(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, dres(32'hFFFF_FFFD), DL, "DIV -7/2");
        add(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, dres(32'hFFFF_FFFF), DL, "REM -7/2");
        add(3'b101, 32'd100, 32'd7, dres(32'h0000_000E), DL, "DIVU 100/7");
        add(3'b111, 32'd100, 32'd7, dres(32'h0000_0002), DL, "REMU 100/7");
        add(3'b100, 32'd5, 32'd0, dres(32'hFFFF_FFFF), 1, "DIV 5/0");
        add(3'b110, 32'd5, 32'd0, dres(32'h0000_0005), 1, "REM 5/0");
        add(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, dres(32'h8000_0000), 1, "DIV ovf");
        add(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "REM ovf");
        add(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DL, "DIVU 8000_0000/max");
        add(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, dres(32'h8000_0000), DL, "REMU 8000_0000/max");
        add(3'b100, 32'd7, 32'hFFFF_FFFE, dres(32'hFFFF_FFFD), DL, "DIV 7/-2");
        add(3'b110, 32'd7, 32'hFFFF_FFFE, dres(32'h0000_0001), DL, "REM 7/-2");
        add(3'b101, 32'hFFFF_FFFF, 32'd1, dres(32'hFFFF_FFFF), DL, "DIVU max/1");
        add(3'b111, 32'd0, 32'd0, 32'h0000_0000, 1, "REMU 0/0");
        add(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, ML, "MUL 0x12345678*16");

        rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = 3'b000; a_i = 32'd0; b_i = 32'd0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        chk("reset stall_o", 32'(stall_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        // Back-to-back MUL issued in the DONE cycle of the previous one.
        issue(3'b000, 32'd6, 32'd7, 32'h0000_002A);
        wait_done(ML, "MUL 6x7", 1'b1, 2'b00);
        issue(3'b000, 32'd2, 32'd3, 32'h0000_0006);
        wait_done(ML, "MUL 2x3 back-to-back", 1'b1, 2'b00);
        idle(3, "after back-to-back");

        // start_i while the multiplier is running must be ignored.
        @(negedge clk);
        issue(3'b000, 32'd6, 32'd7, 32'h0000_002A);
        @(negedge clk);
        a_i = 32'd9; b_i = 32'd9; funct3_i = 3'b011;
        @(negedge clk);
        chk("ignored start mul_a/mul_b", {mul_a_o[15:0], mul_b_o[15:0]}, 32'h0006_0007);
        start_i = 1'b0;
        @(negedge clk);
        chk("ignored start valid_o", 32'(valid_o), 32'd1);
        take("ignored start");
        idle(6, "ignored start");

        // start_i together with flush_i is dropped.
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b000; a_i = 32'd5; b_i = 32'd5;
        #1;
        chk("start+flush stall_o", 32'(stall_o), 32'd0);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        chk("start+flush busy_o", 32'(busy_o), 32'd0);
        idle(5, "start+flush");

        flush_seq(3'b000, 32'd11, 32'd13, 2, "flush MUL");
`ifdef MEXT_DIV_EN
        flush_seq(3'b100, 32'd1000, 32'd3, 10, "flush DIV");
`endif

        @(negedge clk);
        foreach (tbl[i]) begin
            issue(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].e);
            wait_done(tbl[i].lat, tbl[i].nm, ~tbl[i].f3[2], tbl[i].f3[1:0]);
        end
        idle(3, "after table");

        rst_seq(3'b000, 32'd5, 32'd5, 2, "reset mid-MUL");
`ifdef MEXT_DIV_EN
        @(negedge clk);
        issue(3'b000, 32'd6, 32'd7, 32'h0000_002A);
        wait_done(ML, "MUL before reset", 1'b1, 2'b00);
        rst_seq(3'b101, 32'd100, 32'd7, 5, "reset mid-DIV");
`endif
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
